// File: rtl/heart_beat_pkg.sv
// Shared definitions for the heart beat generator and its receive-side monitor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package heart_beat_pkg;

    // Monitor state encoding; software reads this value via status registers.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } hb_state_t;

    // Default half-period, in clock cycles: CLK_VALUE/SPEED_GRADE rounded up
    // to a power of two. The generator calls this too, so both ends agree.
    function automatic int unsigned default_half_period(
        input int unsigned clk_value,
        input int unsigned speed_grade
    );
        int unsigned quot;
        int unsigned pow;
        quot = clk_value / speed_grade;
        pow  = 1;
        for (int i = 0; i < 31; i++) begin
            if (pow < quot) begin
                pow = pow << 1;
            end
        end
        return pow;
    endfunction

    // Width of a counter that must hold values 0..tmo.
    function automatic int period_width(input int unsigned tmo);
        return $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/heart_beat_monitor_if.sv
// Status bundle between the heart beat monitor (master) and its consumer (slave).
// Latency: n/a (wires only).
// Backpressure: none; all status signals are free-running levels/pulses.
// Signals: heart_beat_i (remote line), alive_o, lost_o, state_o, period_o,
// period_vld_o; with HEART_BEAT_MONITOR_STATS_EN also clr_i and err_cnt_o.
// CW defaults to 27, the period width of the monitor's default parameters.
interface heart_beat_monitor_if #(
    parameter int CW = 27
);
    logic          heart_beat_i;
    logic          alive_o;
    logic          lost_o;
    logic [1:0]    state_o;
    logic [CW-1:0] period_o;
    logic          period_vld_o;
`ifdef HEART_BEAT_MONITOR_STATS_EN
    logic          clr_i;
    logic [15:0]   err_cnt_o;
`endif

    modport master (
        input  heart_beat_i,
`ifdef HEART_BEAT_MONITOR_STATS_EN
        input  clr_i,
        output err_cnt_o,
`endif
        output alive_o,
        output lost_o,
        output state_o,
        output period_o,
        output period_vld_o
    );

    modport slave (
        output heart_beat_i,
`ifdef HEART_BEAT_MONITOR_STATS_EN
        output clr_i,
        input  err_cnt_o,
`endif
        input  alive_o,
        input  lost_o,
        input  state_o,
        input  period_o,
        input  period_vld_o
    );

endinterface

// File: rtl/heart_beat_sync_edge.sv
// Brings the asynchronous heart beat line into clk_i and flags each toggle.
// Latency: edge_o rises 2-3 cycles after the input changes (sampling phase).
// Backpressure: none.
// Ports: clk_i, srst_n_i (sync, active-low), async_i (remote line), edge_o.
module heart_beat_sync_edge (
    input  logic clk_i,
    input  logic srst_n_i,
    input  logic async_i,
    output logic edge_o
);

    (* ASYNC_REG = "TRUE" *) logic sync1_q;
    (* ASYNC_REG = "TRUE" *) logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_o = sync2_q ^ prev_q;

endmodule

// File: rtl/heart_beat_monitor.sv
// Checks toggle spacing of a remote heart beat and reports acquire/locked/lost.
// Latency: edge 2-3 cycles after toggle; period on edge cycle; status 1 cycle after state.
// Backpressure: none; outputs are free-running levels and a 1-cycle period pulse.
// Ports: clk_i, srst_n_i (sync, active-low), bus (heart_beat_monitor_if.master).
// Optional: HEART_BEAT_MONITOR_STATS_EN adds bus.clr_i / bus.err_cnt_o error counter.
module heart_beat_monitor
    import heart_beat_pkg::*;
#(
    parameter int unsigned CLK_VALUE       = 100000000,
    parameter int unsigned SPEED_GRADE     = 2,
    parameter int unsigned EXP_HALF_PERIOD = default_half_period(CLK_VALUE, SPEED_GRADE),
    parameter int unsigned TOLERANCE       = EXP_HALF_PERIOD / 8,
    parameter int unsigned LOCK_EDGES      = 3
) (
    input  logic                  clk_i,
    input  logic                  srst_n_i,
    heart_beat_monitor_if.master  bus
);

    localparam int unsigned TMO = EXP_HALF_PERIOD + TOLERANCE + 1;
    localparam int          CW  = period_width(TMO);
    localparam int          GW  = $clog2(LOCK_EDGES + 1);

    localparam logic [CW-1:0] TMO_V  = CW'(TMO);
    localparam logic [CW-1:0] LO_V   = CW'(EXP_HALF_PERIOD - TOLERANCE);
    localparam logic [CW-1:0] HI_V   = CW'(EXP_HALF_PERIOD + TOLERANCE);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_EDGES);

    logic          edge_det;
    logic [CW-1:0] ivl_q;
    hb_state_t     state_q;
    logic [GW-1:0] good_cnt_q;
    logic [GW-1:0] good_cnt_inc;
    logic [CW-1:0] period_q;
    logic          period_vld_q;
    logic [1:0]    state_out_q;
    logic          alive_q;
    logic          lost_q;
    logic          good_ivl;
    logic          timeout;
    logic          measure;

    heart_beat_sync_edge u_sync_edge (
        .clk_i    (clk_i),
        .srst_n_i (srst_n_i),
        .async_i  (bus.heart_beat_i),
        .edge_o   (edge_det)
    );

    // ivl_q still holds the pre-update count on the edge cycle, so it is the
    // measured interval. A simultaneous timeout makes it TMO, which falls
    // outside the window and is therefore classed as a late edge.
    always_comb begin
        good_ivl     = (ivl_q >= LO_V) && (ivl_q <= HI_V);
        timeout      = (ivl_q == TMO_V);
        measure      = edge_det && ((state_q == ACQUIRE) || (state_q == LOCKED));
        good_cnt_inc = good_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            ivl_q        <= '0;
            state_q      <= IDLE;
            good_cnt_q   <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            state_out_q  <= 2'd0;
            alive_q      <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            // Saturating counter: never exceeds TMO, so period_q is
            // implicitly saturated at TMO as well.
            if (edge_det) begin
                ivl_q <= CW'(1);
            end else if (!timeout) begin
                ivl_q <= ivl_q + 1'b1;
            end

            // First edge after IDLE/LOST has no valid start point.
            period_vld_q <= measure;
            if (measure) begin
                period_q <= ivl_q;
            end

            case (state_q)
                IDLE, LOST: begin
                    if (edge_det) begin
                        state_q    <= ACQUIRE;
                        good_cnt_q <= '0;
                    end
                end
                ACQUIRE: begin
                    if (edge_det) begin
                        if (good_ivl) begin
                            good_cnt_q <= good_cnt_inc;
                            if (good_cnt_inc == LOCK_V) begin
                                state_q <= LOCKED;
                            end
                        end else begin
                            good_cnt_q <= '0;
                        end
                    end else if (timeout) begin
                        state_q <= LOST;
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        if (!good_ivl) begin
                            state_q    <= ACQUIRE;
                            good_cnt_q <= '0;
                        end
                    end else if (timeout) begin
                        state_q <= LOST;
                    end
                end
                default: state_q <= IDLE;
            endcase

            state_out_q <= state_q;
            alive_q     <= (state_q == LOCKED);
            lost_q      <= (state_q == LOST);
        end
    end

    assign bus.alive_o      = alive_q;
    assign bus.lost_o       = lost_q;
    assign bus.state_o      = state_out_q;
    assign bus.period_o     = period_q;
    assign bus.period_vld_o = period_vld_q;

`ifdef HEART_BEAT_MONITOR_STATS_EN
    logic        bad_edge;
    logic        lost_entry;
    logic [15:0] err_cnt_q;

    always_comb begin
        bad_edge   = measure && !good_ivl;
        lost_entry = !edge_det && timeout &&
                     ((state_q == ACQUIRE) || (state_q == LOCKED));
    end

    // Clear has priority over a same-cycle error.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i || bus.clr_i) begin
            err_cnt_q <= '0;
        end else if ((bad_edge || lost_entry) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_heart_beat_monitor.sv
// Directed bench for heart_beat_monitor with EXP_HALF_PERIOD=16, TOLERANCE=2,
// LOCK_EDGES=3 (TMO=19). Toggles are driven 1 time unit after a rising edge,
// so each toggle is seen as an edge exactly 3 clocks later.
module tb_heart_beat_monitor;

    localparam int CW = 5;

    logic clk_i    = 1'b0;
    logic srst_n_i = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    heart_beat_monitor_if #(.CW(CW)) bus();

    heart_beat_monitor #(
        .EXP_HALF_PERIOD (16),
        .TOLERANCE       (2),
        .LOCK_EDGES      (3)
    ) dut (
        .clk_i    (clk_i),
        .srst_n_i (srst_n_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic toggle();
        bus.heart_beat_i = ~bus.heart_beat_i;
    endtask

    // Called one cycle after the previous detected edge; returns just after
    // the clock on which the next edge (gap cycles later) is detected.
    task automatic next_edge(input int gap);
        step(gap - 4);
        toggle();
        step(3);
    endtask

    task automatic test_reset();
        srst_n_i = 1'b0;
        bus.heart_beat_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            toggle();
            step(1);
            checks++;
            if (bus.state_o !== 2'd0 || bus.alive_o !== 1'b0 || bus.lost_o !== 1'b0 ||
                bus.period_vld_o !== 1'b0 || bus.period_o !== 5'd0) begin
                errors++;
                $display("FAIL reset[%0d]: state=%0d alive=%b lost=%b vld=%b period=%0d, need all 0",
                         i, bus.state_o, bus.alive_o, bus.lost_o, bus.period_vld_o, bus.period_o);
            end
        end
        bus.heart_beat_i = 1'b0;
    endtask

    // Releases reset together with the first toggle, then 16-cycle toggles.
    task automatic test_lock();
        logic [1:0] exp_state;
        srst_n_i = 1'b1;
        bus.heart_beat_i = 1'b1;
        step(3);
        checks++;
        if (bus.period_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_first_edge_vld: got %b need 0", bus.period_vld_o);
        end
        step(1);
        checks++;
        if (bus.state_o !== 2'd1) begin
            errors++;
            $display("FAIL lock_acquire: state got %0d need 1", bus.state_o);
        end
        for (int k = 2; k <= 4; k++) begin
            next_edge(16);
            checks++;
            if (bus.period_vld_o !== 1'b1 || bus.period_o !== 5'd16) begin
                errors++;
                $display("FAIL lock_period[%0d]: vld=%b period=%0d need 1/16",
                         k, bus.period_vld_o, bus.period_o);
            end
            step(1);
            exp_state = (k == 4) ? 2'd2 : 2'd1;
            checks++;
            if (bus.state_o !== exp_state || bus.alive_o !== (k == 4)) begin
                errors++;
                $display("FAIL lock_state[%0d]: state=%0d alive=%b need %0d/%b",
                         k, bus.state_o, bus.alive_o, exp_state, (k == 4));
            end
        end
    endtask

    // LOST is entered on the clock 19 cycles after the last edge; the status
    // flops show it one cycle later.
    task automatic test_loss();
        step(18);
        checks++;
        if (bus.lost_o !== 1'b0 || bus.alive_o !== 1'b1) begin
            errors++;
            $display("FAIL loss_early: lost=%b alive=%b need 0/1", bus.lost_o, bus.alive_o);
        end
        step(1);
        checks++;
        if (bus.lost_o !== 1'b1 || bus.alive_o !== 1'b0 || bus.state_o !== 2'd3) begin
            errors++;
            $display("FAIL loss: lost=%b alive=%b state=%0d need 1/0/3",
                     bus.lost_o, bus.alive_o, bus.state_o);
        end
        toggle();
        step(3);
        checks++;
        if (bus.period_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL loss_reacquire_vld: got %b need 0", bus.period_vld_o);
        end
        step(1);
        checks++;
        if (bus.state_o !== 2'd1 || bus.lost_o !== 1'b0) begin
            errors++;
            $display("FAIL loss_reacquire: state=%0d lost=%b need 1/0", bus.state_o, bus.lost_o);
        end
    endtask

    task automatic test_boundary();
        int         gaps [10] = '{16, 16, 16, 14, 18, 13, 16, 16, 16, 19};
        logic [1:0] exps [10] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 10; i++) begin
            next_edge(gaps[i]);
            checks++;
            if (bus.period_vld_o !== 1'b1 || bus.period_o !== 5'(gaps[i])) begin
                errors++;
                $display("FAIL boundary_period[%0d]: vld=%b period=%0d need 1/%0d",
                         i, bus.period_vld_o, bus.period_o, gaps[i]);
            end
            step(1);
            checks++;
            if (bus.state_o !== exps[i] || bus.lost_o !== 1'b0) begin
                errors++;
                $display("FAIL boundary_state[%0d] gap %0d: state=%0d lost=%b need %0d/0",
                         i, gaps[i], bus.state_o, bus.lost_o, exps[i]);
            end
        end
    endtask

    task automatic test_reset_pulse();
        for (int i = 0; i < 3; i++) begin
            next_edge(16);
            step(1);
        end
        checks++;
        if (bus.state_o !== 2'd2) begin
            errors++;
            $display("FAIL pulse_prelock: state=%0d need 2", bus.state_o);
        end
        srst_n_i = 1'b0;
        bus.heart_beat_i = 1'b0;
        step(1);
        checks++;
        if (bus.state_o !== 2'd0 || bus.period_o !== 5'd0 || bus.alive_o !== 1'b0 ||
            bus.lost_o !== 1'b0 || bus.period_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL pulse_reset: state=%0d period=%0d alive=%b lost=%b vld=%b need all 0",
                     bus.state_o, bus.period_o, bus.alive_o, bus.lost_o, bus.period_vld_o);
        end
        test_lock();
    endtask

`ifdef HEART_BEAT_MONITOR_STATS_EN
    task automatic test_stats();
        logic [15:0] exp_cnt [2] = '{16'd1, 16'd2};
        checks++;
        if (bus.err_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL stats_start: err=%0d need 0", bus.err_cnt_o);
        end
        for (int i = 0; i < 2; i++) begin
            next_edge(10);
            step(1);
            checks++;
            if (bus.err_cnt_o !== exp_cnt[i]) begin
                errors++;
                $display("FAIL stats_bad[%0d]: err=%0d need %0d", i, bus.err_cnt_o, exp_cnt[i]);
            end
        end
        step(19);
        checks++;
        if (bus.err_cnt_o !== 16'd3 || bus.lost_o !== 1'b1) begin
            errors++;
            $display("FAIL stats_lost: err=%0d lost=%b need 3/1", bus.err_cnt_o, bus.lost_o);
        end
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        toggle();
        step(3);
        step(1);
        checks++;
        if (bus.err_cnt_o !== 16'hFFFE) begin
            errors++;
            $display("FAIL stats_preset: err=%h need fffe", bus.err_cnt_o);
        end
        for (int i = 0; i < 2; i++) begin
            next_edge(10);
            step(1);
            checks++;
            if (bus.err_cnt_o !== 16'hFFFF) begin
                errors++;
                $display("FAIL stats_sat[%0d]: err=%h need ffff", i, bus.err_cnt_o);
            end
        end
        step(6);
        toggle();
        step(2);
        bus.clr_i = 1'b1;
        step(1);
        bus.clr_i = 1'b0;
        checks++;
        if (bus.err_cnt_o !== 16'd0 || bus.period_vld_o !== 1'b1 || bus.period_o !== 5'd10) begin
            errors++;
            $display("FAIL stats_clr: err=%0d vld=%b period=%0d need 0/1/10",
                     bus.err_cnt_o, bus.period_vld_o, bus.period_o);
        end
    endtask
`endif

    initial begin
`ifdef HEART_BEAT_MONITOR_STATS_EN
        bus.clr_i = 1'b0;
`endif
        test_reset();
        test_lock();
        test_loss();
        test_boundary();
        test_reset_pulse();
`ifdef HEART_BEAT_MONITOR_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
